data_mem_ctrl: RTL

DATA_MEM_CTRL -- requirements
Module: data_mem_ctrl

---
 rtl/data_mem_pkg.sv | 7 +
 rtl/data_mem_pipe.sv | 73 +++++++
 rtl/data_mem_ctrl.sv | 99 +++++++++
 3 files changed

// File: rtl/data_mem_pkg.sv
// Shared constants and state type for the data memory controller.
package data_mem_pkg;
   localparam logic RW_READ  = 1'b0;
   localparam logic RW_WRITE = 1'b1;

   typedef enum logic {INIT, RUN} state_t;
endpackage

// File: rtl/data_mem_pipe.sv
// Response delay line: stage 0 is aligned with the registered RAM output,
// later stages just shift valid/err/rdata so the response lands RD_LAT cycles after accept.
module data_mem_pipe
   import data_mem_pkg::*;
#(
   parameter int RD_LAT = 1,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   input  logic              in_err,
   input  logic              in_hit,
   input  logic [DATA_W-1:0] in_rdata,
   output logic              out_valid,
   output logic              out_err,
   output logic [DATA_W-1:0] out_rdata
);

   logic              s0_valid;
   logic              s0_err;
   logic              s0_hit;
   logic [DATA_W-1:0] s0_rdata;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s0_valid <= 1'b0;
         s0_err   <= 1'b0;
         s0_hit   <= 1'b0;
      end else begin
         s0_valid <= in_valid;
         s0_err   <= in_err;
         s0_hit   <= in_hit;
      end
   end

   // RAM output is only meaningful for in-range reads; everything else returns zero.
   assign s0_rdata = s0_hit ? in_rdata : '0;

   generate
      if (RD_LAT == 1) begin : g_direct
         assign out_valid = s0_valid;
         assign out_err   = s0_err;
         assign out_rdata = s0_rdata;
      end else begin : g_delay
         logic [RD_LAT-2:0] v_sr;
         logic [RD_LAT-2:0] e_sr;
         logic [DATA_W-1:0] d_sr [RD_LAT-1];

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               v_sr <= '0;
               e_sr <= '0;
               for (int i = 0; i < RD_LAT - 1; i++) d_sr[i] <= '0;
            end else begin
               v_sr[0] <= s0_valid;
               e_sr[0] <= s0_err;
               d_sr[0] <= s0_rdata;
               for (int i = 1; i < RD_LAT - 1; i++) begin
                  v_sr[i] <= v_sr[i-1];
                  e_sr[i] <= e_sr[i-1];
                  d_sr[i] <= d_sr[i-1];
               end
            end
         end

         assign out_valid = v_sr[RD_LAT-2];
         assign out_err   = e_sr[RD_LAT-2];
         assign out_rdata = d_sr[RD_LAT-2];
      end
   endgenerate

endmodule

// File: rtl/data_mem_ctrl.sv
// Word-addressed data memory with byte-lane writes, a power-up clear sweep,
// fixed-latency in-order responses and out-of-range error reporting.
module data_mem_ctrl
   import data_mem_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int DEPTH  = 512,
   parameter int ADDR_W = 32,
   parameter int RD_LAT = 1
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                req_valid,
   output logic                req_ready,
   input  logic                req_rw,
   input  logic [ADDR_W-1:0]   req_addr,
   input  logic [DATA_W-1:0]   req_wdata,
   input  logic [DATA_W/8-1:0] req_be,
   output logic                rsp_valid,
   output logic [DATA_W-1:0]   rsp_rdata,
   output logic                rsp_err,
   output logic                init_done
);

   localparam int                IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int                BE_W     = DATA_W / 8;
   localparam logic [ADDR_W:0]   DEPTH_X  = (ADDR_W + 1)'(DEPTH);
   localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(DEPTH - 1);

   state_t            state;
   state_t            state_next;
   logic [IDX_W-1:0]  init_cnt;
   logic [DATA_W-1:0] mem [DEPTH];
   logic [DATA_W-1:0] ram_rdata;
   logic [IDX_W-1:0]  idx;
   logic              accept;
   logic              in_range;
   logic              wr_hit;
   logic              rd_hit;

   // Full-width compare so large addresses can never alias onto a valid word.
   assign in_range = {1'b0, req_addr} < DEPTH_X;
   assign idx      = req_addr[IDX_W-1:0];
   assign accept   = req_valid && req_ready;
   assign wr_hit   = accept && in_range && (req_rw == RW_WRITE);
   assign rd_hit   = accept && in_range && (req_rw == RW_READ);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= INIT;
         init_cnt <= '0;
      end else begin
         state <= state_next;
         if (state == INIT && init_cnt != LAST_IDX) init_cnt <= init_cnt + IDX_W'(1);
      end
   end

   always_comb begin
      state_next = state;
      req_ready  = 1'b0;
      init_done  = 1'b0;
      case (state)
         INIT: if (init_cnt == LAST_IDX) state_next = RUN;
         RUN: begin
            req_ready = 1'b1;
            init_done = 1'b1;
         end
         default: state_next = INIT;
      endcase
   end

   // Single-port array: one access per cycle, either the sweep, a write or a read.
   always_ff @(posedge clk) begin
      if (state == INIT) begin
         mem[init_cnt] <= '0;
      end else if (wr_hit) begin
         for (int b = 0; b < BE_W; b++) begin
            if (req_be[b]) mem[idx][8*b +: 8] <= req_wdata[8*b +: 8];
         end
      end
      if (rd_hit) ram_rdata <= mem[idx];
   end

   data_mem_pipe #(
      .RD_LAT (RD_LAT),
      .DATA_W (DATA_W)
   ) u_pipe (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (accept),
      .in_err    (accept && !in_range),
      .in_hit    (rd_hit),
      .in_rdata  (ram_rdata),
      .out_valid (rsp_valid),
      .out_err   (rsp_err),
      .out_rdata (rsp_rdata)
   );

endmodule
